// File: rtl/sram_mrnw_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_mrnw_pipe_pkg                                           |
// | Description : Shared types, constants and helpers for the multi-read /     |
// |               multi-write register-file SRAM and its write arbiter.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sram_mrnw_pipe_pkg;

    // Clear sequencer state encoding
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Default geometry shared by the rename-map and PRF instances
    localparam int C_DEF_DEPTH = 16;
    localparam int C_DEF_INDEX = 4;
    localparam int C_DEF_WIDTH = 8;

    // Low bit of port `port` inside a packed bus of `width`-bit slices
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_wr_arbiter                                              |
// | Description : Per-row priority select across all write ports. Produces a   |
// |               row-hit vector and the winning data for each row; the        |
// |               highest-numbered enabled port targeting a row wins.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_wr_arbiter
    import sram_mrnw_pipe_pkg::*;
#(
    parameter int NUM_WR     = 4,
    parameter int SRAM_DEPTH = C_DEF_DEPTH,
    parameter int SRAM_WIDTH = C_DEF_WIDTH
) (
    input  logic [NUM_WR*SRAM_DEPTH-1:0]     wr_dec,
    input  logic [NUM_WR*SRAM_WIDTH-1:0]     wr_data,
    output logic [SRAM_DEPTH-1:0]            row_hit,
    output logic [SRAM_DEPTH*SRAM_WIDTH-1:0] row_data
);

    for (genvar r = 0; r < SRAM_DEPTH; r++) begin : g_row
        logic                  w_hit;
        logic [SRAM_WIDTH-1:0] w_data;

        // Scan ports low to high so the highest-numbered hit is the last assignment
        always_comb begin
            w_hit  = 1'b0;
            w_data = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_dec[p*SRAM_DEPTH + r]) begin
                    w_hit  = 1'b1;
                    w_data = wr_data[slice_lo(p, SRAM_WIDTH) +: SRAM_WIDTH];
                end
            end
        end

        assign row_hit[r]                          = w_hit;
        assign row_data[r*SRAM_WIDTH +: SRAM_WIDTH] = w_data;
    end

endmodule
`default_nettype wire

// File: rtl/sram_mrnw_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_mrnw_pipe                                               |
// | Description : Parametrised multi-read / multi-write register-file SRAM     |
// |               with registered reads, same-cycle write-to-read bypass and   |
// |               a one-row-per-cycle background clear of the upper rows.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_mrnw_pipe
    import sram_mrnw_pipe_pkg::*;
#(
    parameter int NUM_RD     = 8,
    parameter int NUM_WR     = 4,
    parameter int SRAM_DEPTH = C_DEF_DEPTH,
    parameter int SRAM_INDEX = C_DEF_INDEX,
    parameter int SRAM_WIDTH = C_DEF_WIDTH,
    parameter int CLR_BASE   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_RD*SRAM_INDEX-1:0] rd_addr_i,
    output logic [NUM_RD*SRAM_WIDTH-1:0] rd_data_o,
    output logic [NUM_RD*SRAM_DEPTH-1:0] rd_dec_o,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR*SRAM_INDEX-1:0] wr_addr_i,
    input  logic [NUM_WR*SRAM_WIDTH-1:0] wr_data_i,
    output logic [NUM_WR*SRAM_DEPTH-1:0] wr_dec_o,
    input  logic                         clr_i,
    output logic                         busy_o
);

    // A base equal to the depth means the array has no clearable rows
    localparam bit                    c_clr_en   = (CLR_BASE < SRAM_DEPTH);
    localparam logic [SRAM_INDEX-1:0] c_clr_base = SRAM_INDEX'(CLR_BASE);
    localparam logic [SRAM_INDEX-1:0] c_last_row = SRAM_INDEX'(SRAM_DEPTH - 1);

    clr_state_e                     r_state;
    logic [SRAM_INDEX-1:0]          r_clr_ptr;
    logic [SRAM_WIDTH-1:0]          r_mem [SRAM_DEPTH];

    logic [NUM_WR-1:0]              w_wr_en_eff;
    logic [NUM_WR*SRAM_DEPTH-1:0]   w_wr_dec;
    logic [NUM_RD*SRAM_DEPTH-1:0]   w_rd_dec;
    logic [SRAM_DEPTH-1:0]          w_arb_hit;
    logic [SRAM_DEPTH*SRAM_WIDTH-1:0] w_arb_data;
    logic [SRAM_DEPTH-1:0]          w_row_we;
    logic [SRAM_DEPTH*SRAM_WIDTH-1:0] w_row_wd;
    logic [SRAM_WIDTH-1:0]          w_rd_next [NUM_RD];

    assign busy_o      = (r_state == ST_CLEAR);
    assign w_wr_en_eff = wr_en_i & {NUM_WR{~busy_o}};

    // Write-address decode, gated by the effective (non-busy) enable
    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_port
        for (genvar r = 0; r < SRAM_DEPTH; r++) begin : g_wr_row
            assign w_wr_dec[p*SRAM_DEPTH + r] = w_wr_en_eff[p] &&
                (wr_addr_i[slice_lo(p, SRAM_INDEX) +: SRAM_INDEX] == SRAM_INDEX'(r));
        end
    end
    assign wr_dec_o = w_wr_dec;

    // Read-address decode
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
        for (genvar r = 0; r < SRAM_DEPTH; r++) begin : g_rd_row
            assign w_rd_dec[k*SRAM_DEPTH + r] =
                (rd_addr_i[slice_lo(k, SRAM_INDEX) +: SRAM_INDEX] == SRAM_INDEX'(r));
        end
    end
    assign rd_dec_o = w_rd_dec;

    sram_wr_arbiter #(
        .NUM_WR     (NUM_WR),
        .SRAM_DEPTH (SRAM_DEPTH),
        .SRAM_WIDTH (SRAM_WIDTH)
    ) u_wr_arbiter (
        .wr_dec   (w_wr_dec),
        .wr_data  (wr_data_i),
        .row_hit  (w_arb_hit),
        .row_data (w_arb_data)
    );

    // The clear write is merged in as just another row write so reads bypass it too
    for (genvar r = 0; r < SRAM_DEPTH; r++) begin : g_row_wr
        logic w_clr_hit;
        assign w_clr_hit   = busy_o && (r_clr_ptr == SRAM_INDEX'(r));
        assign w_row_we[r] = w_clr_hit | w_arb_hit[r];
        assign w_row_wd[r*SRAM_WIDTH +: SRAM_WIDTH] =
            w_clr_hit ? '0 : w_arb_data[r*SRAM_WIDTH +: SRAM_WIDTH];
    end

    // Per-port next read value: pending row write if any, else stored row
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_mux
        always_comb begin
            w_rd_next[k] = '0;
            for (int r = 0; r < SRAM_DEPTH; r++) begin
                if (w_rd_dec[k*SRAM_DEPTH + r]) begin
                    w_rd_next[k] = w_row_we[r] ? w_row_wd[r*SRAM_WIDTH +: SRAM_WIDTH]
                                               : r_mem[r];
                end
            end
        end
    end

    // Clear sequencer: reset or clr_i (when idle) starts a sweep from CLR_BASE
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clr_ptr <= c_clr_en ? c_clr_base : '0;
            r_state   <= c_clr_en ? ST_CLEAR : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_i && c_clr_en) begin
                        r_state   <= ST_CLEAR;
                        r_clr_ptr <= c_clr_base;
                    end
                end
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == c_last_row) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Array update; the reset cycle leaves contents untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < SRAM_DEPTH; r++) begin
                if (w_row_we[r]) begin
                    r_mem[r] <= w_row_wd[r*SRAM_WIDTH +: SRAM_WIDTH];
                end
            end
        end
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_o <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                rd_data_o[k*SRAM_WIDTH +: SRAM_WIDTH] <= w_rd_next[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_mrnw_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sram_mrnw_pipe                                            |
// | Description : Directed self-checking bench: default geometry with          |
// |               CLR_BASE=4, plus a 2R1W 64x7 instance with no clear range.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sram_mrnw_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: 8R4W, 16x8, clear rows 4..15
    logic         rst_a = 1'b1;
    logic [31:0]  rd_addr_a = '0;
    logic [63:0]  rd_data_a;
    logic [127:0] rd_dec_a;
    logic [3:0]   wr_en_a = '0;
    logic [15:0]  wr_addr_a = '0;
    logic [31:0]  wr_data_a = '0;
    logic [63:0]  wr_dec_a;
    logic         clr_a = 1'b0;
    logic         busy_a;

    sram_mrnw_pipe #(
        .NUM_RD(8), .NUM_WR(4), .SRAM_DEPTH(16), .SRAM_INDEX(4),
        .SRAM_WIDTH(8), .CLR_BASE(4)
    ) dut_a (
        .clk(clk), .reset(rst_a), .rd_addr_i(rd_addr_a), .rd_data_o(rd_data_a),
        .rd_dec_o(rd_dec_a), .wr_en_i(wr_en_a), .wr_addr_i(wr_addr_a),
        .wr_data_i(wr_data_a), .wr_dec_o(wr_dec_a), .clr_i(clr_a), .busy_o(busy_a)
    );

    // Instance B: 2R1W, 64x7, empty clear range
    logic         rst_b = 1'b0;
    logic [11:0]  rd_addr_b = '0;
    logic [13:0]  rd_data_b;
    logic [127:0] rd_dec_b;
    logic [0:0]   wr_en_b = '0;
    logic [5:0]   wr_addr_b = '0;
    logic [6:0]   wr_data_b = '0;
    logic [63:0]  wr_dec_b;
    logic         clr_b = 1'b0;
    logic         busy_b;

    sram_mrnw_pipe #(
        .NUM_RD(2), .NUM_WR(1), .SRAM_DEPTH(64), .SRAM_INDEX(6),
        .SRAM_WIDTH(7), .CLR_BASE(64)
    ) dut_b (
        .clk(clk), .reset(rst_b), .rd_addr_i(rd_addr_b), .rd_data_o(rd_data_b),
        .rd_dec_o(rd_dec_b), .wr_en_i(wr_en_b), .wr_addr_i(wr_addr_b),
        .wr_data_i(wr_data_b), .wr_dec_o(wr_dec_b), .clr_i(clr_b), .busy_o(busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read rows base..base+7 on ports 0..7 and compare against preload image
    task automatic check_rows_a(input int base, input string tag);
        logic [7:0] exp;
        for (int k = 0; k < 8; k++) rd_addr_a[k*4 +: 4] = 4'(base + k);
        step();
        for (int k = 0; k < 8; k++) begin
            exp = (base + k < 4) ? 8'(8'h40 + base + k) : 8'h00;
            chk($sformatf("%s_row%0d", tag, base + k), 64'(rd_data_a[k*8 +: 8]), 64'(exp));
        end
    endtask

    // Count consecutive busy samples, starting from the current one
    task automatic count_busy_a(output int cnt);
        cnt = 0;
        while (busy_a && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    logic [6:0] model [64];
    logic [6:0] exp0, exp1;
    int         cnt;
    int         ra0, ra1, wa;

    initial begin
        // ---------------- Instance A ----------------
        // Bring-up reset and clear so rows 4..15 are defined
        rst_a = 1'b0;
        step();
        rst_a = 1'b1;
        count_busy_a(cnt);

        // Preload every row with 0x40+row, four rows per cycle
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 4; p++) begin
                wr_en_a[p]          = 1'b1;
                wr_addr_a[p*4 +: 4] = 4'(4*c + p);
                wr_data_a[p*8 +: 8] = 8'(8'h40 + 4*c + p);
            end
            step();
        end
        wr_en_a = '0;

        // Reset and clear: busy for 12 cycles, upper rows zero, lower kept
        rst_a = 1'b0;
        step();
        chk("rst_rd_data", rd_data_a, 64'h0);
        chk("rst_busy", 64'(busy_a), 64'h1);
        rst_a = 1'b1;
        count_busy_a(cnt);
        chk("rst_busy_len", 64'(cnt), 64'd12);
        check_rows_a(0, "rst");
        check_rows_a(8, "rst");

        // Read decode is one-hot
        rd_addr_a[3*4 +: 4] = 4'd11;
        rd_addr_a[0 +: 4]   = 4'd0;
        #1;
        chk("rd_dec_p3", 64'(rd_dec_a[3*16 +: 16]), 64'h0800);
        chk("rd_dec_p0", 64'(rd_dec_a[0 +: 16]), 64'h0001);

        // Collision on row 5: ports 0,2,3 -> port 3 wins
        wr_en_a = 4'b1101;
        wr_addr_a = {4'd5, 4'd5, 4'd0, 4'd5};
        wr_data_a = {8'h33, 8'h22, 8'h00, 8'h11};
        #1;
        chk("wr_dec_coll", wr_dec_a, 64'h0020_0020_0000_0020);
        step();
        wr_en_a = '0;
        rd_addr_a[0 +: 4] = 4'd5;
        step();
        chk("collision_row5", 64'(rd_data_a[0 +: 8]), 64'h33);

        // Bypass: port 1 writes 0xA5 to row 9 while read port 6 reads row 9
        wr_en_a = 4'b0010;
        wr_addr_a[4 +: 4] = 4'd9;
        wr_data_a[8 +: 8] = 8'hA5;
        rd_addr_a[6*4 +: 4] = 4'd9;
        step();
        chk("bypass_same", 64'(rd_data_a[6*8 +: 8]), 64'hA5);
        wr_en_a = '0;
        step();
        chk("bypass_next", 64'(rd_data_a[6*8 +: 8]), 64'hA5);

        // Writes during clear are dropped; second clr_i does not extend busy
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        cnt = 0;
        while (busy_a && cnt < 100) begin
            if (cnt == 0) begin
                wr_en_a = 4'b0011;
                wr_addr_a[0 +: 4] = 4'd10;
                wr_data_a[0 +: 8] = 8'h7E;
                wr_addr_a[4 +: 4] = 4'd2;
                wr_data_a[8 +: 8] = 8'h7E;
                #1;
                chk("clr_wr_dec", wr_dec_a, 64'h0);
            end
            if (cnt == 1) wr_en_a = '0;
            if (cnt == 3) clr_a = 1'b1;
            if (cnt == 4) clr_a = 1'b0;
            cnt++;
            step();
        end
        chk("clr_busy_len", 64'(cnt), 64'd12);
        check_rows_a(0, "clr");
        check_rows_a(8, "clr");

        // Reset mid-clear at clr_ptr=8 restarts the full sequence
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        repeat (4) step();
        chk("mid_busy", 64'(busy_a), 64'h1);
        rst_a = 1'b0;
        step();
        rst_a = 1'b1;
        count_busy_a(cnt);
        chk("mid_busy_len", 64'(cnt), 64'd12);

        // ---------------- Instance B ----------------
        step();
        chk("b_rst_rd_data", 64'(rd_data_b), 64'h0);
        rst_b = 1'b1;
        step();
        chk("b_busy_rst", 64'(busy_b), 64'h0);
        clr_b = 1'b1;
        step();
        chk("b_busy_clr", 64'(busy_b), 64'h0);
        clr_b = 1'b0;
        step();
        chk("b_busy_after", 64'(busy_b), 64'h0);

        // Fill every row so the model is fully defined
        wr_en_b = 1'b1;
        for (int i = 0; i < 64; i++) begin
            wr_addr_b = 6'(i);
            wr_data_b = 7'($urandom);
            model[i]  = wr_data_b;
            step();
        end

        // Random traffic against the reference model, 1-cycle read latency
        for (int i = 0; i < 300; i++) begin
            wa  = int'($urandom_range(0, 63));
            ra0 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 63));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 63));
            wr_en_b   = 1'($urandom_range(0, 1));
            wr_addr_b = 6'(wa);
            wr_data_b = 7'($urandom);
            rd_addr_b = {6'(ra1), 6'(ra0)};
            exp0 = (wr_en_b[0] && wa == ra0) ? wr_data_b : model[ra0];
            exp1 = (wr_en_b[0] && wa == ra1) ? wr_data_b : model[ra1];
            if (wr_en_b[0]) model[wa] = wr_data_b;
            step();
            chk($sformatf("b_rd0_%0d", i), 64'(rd_data_b[0 +: 7]), 64'(exp0));
            chk($sformatf("b_rd1_%0d", i), 64'(rd_data_b[7 +: 7]), 64'(exp1));
        end
        wr_en_b = '0;
        chk("b_busy_end", 64'(busy_b), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_mrnw_pipe.md
# sram_mrnw_pipe

Parametrised multi-read / multi-write register-file SRAM for rename-map, free-list and physical-register-file storage. It generalises the fixed 8R4W array:
- port counts, depth and width are parameters;
- reads are registered (one-cycle latency) with same-cycle write-to-read bypass;
- simultaneous writes to one row resolve deterministically;
- the reset clear of the upper rows runs as a sequenced, one-row-per-cycle background operation that software/pipeline can also re-trigger.

## Interface
Parameters:
- `NUM_RD`, default 8: number of read ports.
- `NUM_WR`, default 4: number of write ports.
- `SRAM_DEPTH`, default 16: number of rows.
- `SRAM_INDEX`, default 4: address width, equal to clog2(`SRAM_DEPTH`).
- `SRAM_WIDTH`, default 8: row width.
- `CLR_BASE`, default 0: first row cleared by the clear sequence. Rows below it are never cleared. Legal range is 0..`SRAM_DEPTH`.

Ports:
- `clk`, in, 1: single clock, all logic on its rising edge.
- `reset`, in, 1: synchronous, active-low (0 = reset).
- `rd_addr_i`, in, `NUM_RD*SRAM_INDEX`: packed read addresses; port k occupies bits [k*SRAM_INDEX +: SRAM_INDEX].
- `rd_data_o`, out, `NUM_RD*SRAM_WIDTH`: registered read data, packed the same way.
- `rd_dec_o`, out, `NUM_RD*SRAM_DEPTH`: combinational one-hot decode of each `rd_addr_i`.
- `wr_en_i`, in, `NUM_WR`: per-port write enable.
- `wr_addr_i`, in, `NUM_WR*SRAM_INDEX`: packed write addresses.
- `wr_data_i`, in, `NUM_WR*SRAM_WIDTH`: packed write data.
- `wr_dec_o`, out, `NUM_WR*SRAM_DEPTH`: combinational one-hot decode of each write address, gated by the effective write enable.
- `clr_i`, in, 1: request a clear of rows `CLR_BASE`..`SRAM_DEPTH`-1.
- `busy_o`, out, 1: clear sequence in progress.

## Operation
- FSM states: IDLE and CLEAR. A row pointer `clr_ptr`, `SRAM_INDEX` bits wide, tracks progress.
- **Reset** (`reset`=0 at an edge):
  - If `CLR_BASE` < `SRAM_DEPTH`: state becomes CLEAR and `clr_ptr` becomes `CLR_BASE`.
  - Otherwise: state becomes IDLE.
  - `rd_data_o` becomes 0.
  - Array contents are not touched during the reset cycle.
- **CLEAR**:
  - Each cycle writes 0 to row `clr_ptr`, then increments `clr_ptr`.
  - When the cycle clears row `SRAM_DEPTH`-1, the next state is IDLE.
  - `busy_o` = 1 throughout CLEAR.
  - `clr_i` is ignored (no restart).
  - User writes are dropped: effective enable = `wr_en_i` AND NOT `busy_o`, so `wr_dec_o` = 0.
- **IDLE**:
  - `clr_i`=1 moves to CLEAR with `clr_ptr`=`CLR_BASE` on the next edge.
  - If `CLR_BASE`=`SRAM_DEPTH`, `clr_i` has no effect.
  - User writes in the same cycle as `clr_i` still commit; that cycle is IDLE.
- **Writes**: at each edge, every port with an effective enable writes its row. If several ports target the same row, the highest-numbered port wins.
- **Reads**:
  - `rd_data_o[k]` is registered at the edge.
  - If any effective write in that cycle targets `rd_addr_i[k]`, the register captures the winning write data (bypass).
  - Otherwise it captures the current array row.
  - During CLEAR, a read of row `clr_ptr` captures 0 (the clear write is bypassed like any other write).
- Rows below `CLR_BASE` keep their contents through reset and clear. Their contents are undefined after power-up.

## Timing
- Read latency is 1 cycle. The address is presented in cycle n; data is valid after edge n+1 and held until the next edge.
- Write-to-read latency is 0 extra cycles: a read of the same address in the same cycle as the write returns the new data.
- Clear duration is `SRAM_DEPTH`-`CLR_BASE` cycles. `busy_o` rises on the edge that enters CLEAR and falls on the edge after the final row is cleared.
- Reset asserted mid-CLEAR restarts the sequence at `CLR_BASE`.
- `rd_dec_o` and `wr_dec_o` are purely combinational, with no edge.

## Structure
- Shared package holds:
  - the state encoding (IDLE=1'b0, CLEAR=1'b1);
  - a helper function for the packed-slice index;
  - the default depth, width and index constants used by the rename and PRF instances.
- One sub-module, `sram_wr_arbiter`: per-row priority select across `NUM_WR` ports. It produces a row-hit vector and the winning data. The array write and the read bypass both use it.
- Top level holds the FSM, `clr_ptr`, the array and the registered read mux.

## Test plan
- **Reset and clear.** Defaults with `CLR_BASE`=4; hold `reset`=0 for 1 cycle, then release. Required:
  - `busy_o`=1 for exactly 12 cycles;
  - rows 4..15 read 0 afterwards;
  - rows 0..3 unchanged from values preloaded before reset.
- **Write-port collision.** Ports 0, 2 and 3 all write row 5 with 0x11, 0x22, 0x33. Required: row 5 = 0x33 next cycle.
- **Bypass.** Port 1 writes 0xA5 to row 9 while read port 6 addresses row 9 in the same cycle. Required: `rd_data_o[6]` = 0xA5 after that edge. A read of row 9 one cycle later also returns 0xA5.
- **Writes during clear.** Assert `clr_i` in IDLE, then issue a write of 0x7E to row 10 while `busy_o`=1. Required:
  - the write is dropped and `wr_dec_o`=0;
  - row 10 = 0 after clear completes;
  - a second `clr_i` during CLEAR does not extend `busy_o`.
- **Reset mid-clear.** Assert reset at `clr_ptr`=8 (`CLR_BASE`=4). Required: the sequence restarts and `busy_o` lasts 12 more cycles after reset release.
- **Parameter sweep.** Run `NUM_RD`=2, `NUM_WR`=1, `SRAM_DEPTH`=64, `SRAM_WIDTH`=7, `CLR_BASE`=64. Required:
  - no clear: `busy_o` stays 0 after reset and `clr_i` has no effect;
  - random writes/reads match a reference model with 1-cycle read latency.
